inv_sched: RTL

INV_SCHED -- requirements
Module: inv_sched

---
 rtl/inv_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inv_sched.sv
// Two-requester modular-inverse scheduler: round-robin grant into a single
// iterative extended-Euclid engine, one result strobe per accepted request.
module inv_sched #(
  parameter int IP_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  input  logic [IP_WIDTH-1:0] req0_a,
  input  logic [IP_WIDTH-1:0] req0_p,
  input  logic                req1_valid,
  input  logic [IP_WIDTH-1:0] req1_a,
  input  logic [IP_WIDTH-1:0] req1_p,
  output logic                req0_ready,
  output logic                req1_ready,
  output logic                out_valid,
  output logic [IP_WIDTH-1:0] out_inv,
  output logic                out_id,
  output logic                out_err
);

  localparam int TW = IP_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IP_WIDTH-1:0]        r0_q, r0_d, r1_q, r1_d, p_q, p_d;
  logic signed [TW-1:0]       t0_q, t0_d, t1_q, t1_d;
  logic                       id_q, id_d, last_q, last_d;
  logic [IP_WIDTH-1:0]        inv_q, inv_d;
  logic                       oid_q, oid_d, err_q, err_d;

  logic                       gnt0, gnt1;
  logic [IP_WIDTH-1:0]        acc_a, acc_p, q, inv_w;
  logic signed [TW-1:0]       qs;

  // last_q==1 means requester 1 was served last, so requester 0 wins a tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc_a      = gnt1 ? req1_a : req0_a;
  assign acc_p      = gnt1 ? req1_p : req0_p;
  assign q          = (r1_q != '0) ? r0_q / r1_q : '0;
  assign qs         = $signed({2'b00, q});
  // low bits of (t0 + p) when t0 is negative; modular add gives the truncation
  assign inv_w      = t0_q[IP_WIDTH-1:0] + (t0_q[TW-1] ? p_q : '0);

  always_comb begin
    state_d = state_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    p_d     = p_q;
    t0_d    = t0_q;
    t1_d    = t1_q;
    id_d    = id_q;
    last_d  = last_q;
    inv_d   = inv_q;
    oid_d   = oid_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d   = gnt1;
          last_d = gnt1;
          r0_d   = acc_p;
          r1_d   = acc_a;
          p_d    = acc_p;
          t0_d   = '0;
          t1_d   = TW'(1);
          if (acc_p < IP_WIDTH'(2) || acc_a >= acc_p) begin
            state_d = DONE;
            oid_d   = gnt1;
            err_d   = 1'b1;
            inv_d   = '0;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (r1_q != '0) begin
          r0_d = r1_q;
          r1_d = r0_q - q * r1_q;
          t0_d = t1_q;
          t1_d = t0_q - qs * t1_q;
        end else begin
          state_d = DONE;
          oid_d   = id_q;
          err_d   = (r0_q != IP_WIDTH'(1));
          inv_d   = (r0_q != IP_WIDTH'(1)) ? '0 : inv_w;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      p_q     <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      inv_q   <= '0;
      oid_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      p_q     <= p_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      id_q    <= id_d;
      last_q  <= last_d;
      inv_q   <= inv_d;
      oid_q   <= oid_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_inv   = inv_q;
  assign out_id    = oid_q;
  assign out_err   = err_q;

endmodule
